// File: rtl/decoder_3x8.sv
// Registered 3-to-8 line decoder with active-high enable.
// The output is a one-hot strobe for the sampled select, or all zeros when disabled or held in reset.
`timescale 1ns/1ps

module decoder_3x8 (
  input  logic [2:0] a,
  input  logic       e,
  output logic [7:0] d,
  input  logic       clk,
  input  logic       rst_n
);

  logic [7:0] w_dNext;
  logic [7:0] r_d;

  always_comb begin
    w_dNext = 8'h00;
    if (e) begin
      w_dNext = 8'b0000_0001 << a;
    end
  end

  // Reset clears the strobe at once, without waiting for a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d <= 8'h00;
    end else begin
      r_d <= w_dNext;
    end
  end

  assign d = r_d;

endmodule

// File: tb/tb_decoder_3x8.sv
// Self-checking bench for decoder_3x8.
// A scoreboard queue holds the value expected after each driven edge.
`timescale 1ns/1ps

module tb_decoder_3x8;

  logic [2:0] a;
  logic       e;
  logic [7:0] d;
  logic       clk;
  logic       rst_n;

  int total;
  int bad;

  logic [7:0] expQ[$];
  logic [7:0] oneHot[8];

  decoder_3x8 dut (
    .a    (a),
    .e    (e),
    .d    (d),
    .clk  (clk),
    .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one {e,a} pair ahead of the edge, then compare the scoreboard head just after it
  task automatic applyStimulus(input logic en, input logic [2:0] sel, input string tag);
    logic [7:0] expVal;
    @(negedge clk);
    e = en;
    a = sel;
    expQ.push_back(en ? oneHot[sel] : 8'h00);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, d, 8'hxx);
    end else begin
      expVal = expQ.pop_front();
      checkOutput(tag, d, expVal);
    end
  endtask

  initial begin
    logic       rEn;
    logic [2:0] rSel;
    logic [7:0] popCnt;

    total = 0;
    bad   = 0;
    oneHot[0] = 8'h01; oneHot[1] = 8'h02; oneHot[2] = 8'h04; oneHot[3] = 8'h08;
    oneHot[4] = 8'h10; oneHot[5] = 8'h20; oneHot[6] = 8'h40; oneHot[7] = 8'h80;

    rst_n = 1'b0;
    e     = 1'b1;
    a     = 3'd5;
    #1;
    checkOutput("rstInit", d, 8'h00);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("rstHold", d, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd5, "rstRelease");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'(i), "disabledSweep");
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), "enabledSweep");
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus((i % 2) == 0, 3'd3, "enableToggle");
    end

    applyStimulus(1'b1, 3'd2, "preMidChange");
    #2;
    a = 3'd6;
    e = 1'b0;
    #1;
    checkOutput("midCycleChange", d, 8'h04);

    applyStimulus(1'b1, 3'd7, "preAsync");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncClear", d, 8'h00);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("postRelease", d, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("resume", d, 8'h80);

    for (int i = 0; i < 1000; i++) begin
      rEn  = 1'($urandom_range(0, 1));
      rSel = 3'($urandom_range(0, 7));
      applyStimulus(rEn, rSel, "random");
      popCnt = 8'($countones(d));
      checkOutput("popcount", popCnt, {7'b0, rEn});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
